// File: rtl/median_pkg.sv
// Shared types and window geometry for the sliding-window median controller
// and its 11-input sorting network.
package median_pkg;
    localparam int WIN = 11;
    localparam int MID = 5;

    typedef logic [31:0] data_t;
    typedef logic [3:0]  fill_t;

    localparam fill_t FILL_FULL = 4'(WIN);
endpackage

// File: rtl/median_window_ctrl_if.sv
// Sample input stream and median output stream of median_window_ctrl.
// master drives samples and consumes medians; slave is the controller.
interface median_window_ctrl_if;
    import median_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  in_last;
    logic  out_valid;
    logic  out_ready;
    data_t out_median;
    logic  out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_median, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_median, out_last
    );
endinterface

// File: rtl/median_sort_net_11.sv
// Purely combinational ascending sort of 11 unsigned words (odd-even
// transposition network; WIN rounds are sufficient for WIN inputs).
module median_sort_net_11
    import median_pkg::*;
(
    input  data_t din  [WIN],
    output data_t dout [WIN]
);

    data_t v [WIN];

    always_comb begin
        v = din;
        for (int s = 0; s < WIN; s++) begin
            for (int i = 0; i < WIN - 1; i++) begin
                if (((i % 2) == (s % 2)) && (v[i] > v[i+1])) begin
                    {v[i], v[i+1]} = {v[i+1], v[i]};
                end
            end
        end
        dout = v;
    end

endmodule

// File: rtl/median_window_ctrl.sv
// Sliding 11-sample median sequencer: window shift register, fill/frame
// tracking and a one-entry output register. Define MEDIAN_PIPE_REG_EN to add
// a register stage in front of the sort network (latency 2 instead of 1).
module median_window_ctrl
    import median_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    median_window_ctrl_if.slave   strm,
    output logic                  short_frame,
    output fill_t                 fill_count
);

    data_t w_q      [WIN-1];
    data_t win_in   [WIN];
    data_t sort_in  [WIN];
    data_t sort_out [WIN];
    fill_t fill_inc;
    logic  accept;
    logic  emit;
    logic  in_ready;
    logic  load_emit;
    logic  load_last;
    logic  out_valid_q;
    logic  out_last_q;
    data_t out_median_q;

    assign fill_inc = (fill_count == FILL_FULL) ? FILL_FULL : fill_count + 4'd1;
    assign accept   = strm.in_valid && in_ready;
    assign emit     = accept && (fill_inc == FILL_FULL);

    always_comb begin
        win_in[0] = strm.in_data;
        for (int i = 0; i < WIN - 1; i++) begin
            win_in[i+1] = w_q[i];
        end
    end

    // Window contents survive frame ends; fill_count alone decides validity.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN - 1; i++) begin
                w_q[i] <= '0;
            end
            fill_count  <= '0;
            short_frame <= 1'b0;
        end else begin
            short_frame <= accept && strm.in_last && !emit;
            if (accept) begin
                w_q[0] <= strm.in_data;
                for (int i = 1; i < WIN - 1; i++) begin
                    w_q[i] <= w_q[i-1];
                end
                fill_count <= strm.in_last ? '0 : fill_inc;
            end
        end
    end

`ifdef MEDIAN_PIPE_REG_EN
    data_t s1_data [WIN];
    logic  s1_valid;
    logic  s1_emit;
    logic  s1_last;
    logic  out_load;

    assign in_ready  = !rst && (!s1_valid || !out_valid_q || strm.out_ready);
    assign out_load  = s1_valid && (!out_valid_q || strm.out_ready);
    assign load_emit = out_load && s1_emit;
    assign load_last = s1_last;
    assign sort_in   = s1_data;

    // A new accept may overwrite s1 only in a cycle where s1 is also draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) begin
                s1_data[i] <= '0;
            end
            s1_valid <= 1'b0;
            s1_emit  <= 1'b0;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_data  <= win_in;
            s1_valid <= 1'b1;
            s1_emit  <= emit;
            s1_last  <= strm.in_last;
        end else if (out_load) begin
            s1_valid <= 1'b0;
        end
    end
`else
    assign in_ready  = !rst && (!out_valid_q || strm.out_ready);
    assign load_emit = emit;
    assign load_last = strm.in_last;
    assign sort_in   = win_in;
`endif

    median_sort_net_11 u_sort (
        .din  (sort_in),
        .dout (sort_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_median_q <= '0;
            out_last_q   <= 1'b0;
        end else if (load_emit) begin
            out_valid_q  <= 1'b1;
            out_median_q <= sort_out[MID];
            out_last_q   <= load_last;
        end else if (strm.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign strm.in_ready   = in_ready;
    assign strm.out_valid  = out_valid_q;
    assign strm.out_median = out_median_q;
    assign strm.out_last   = out_last_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed scoreboard bench for median_window_ctrl; honours MEDIAN_PIPE_REG_EN
// to select the expected latency.
module tb_median_window_ctrl;
    import median_pkg::*;

`ifdef MEDIAN_PIPE_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        data_t med;
        logic  last;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  short_frame;
    fill_t fill_count;

    median_window_ctrl_if strm ();

    median_window_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .strm        (strm.slave),
        .short_frame (short_frame),
        .fill_count  (fill_count)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q [$];
    data_t win_m [$];
    int    fill_m = 0;
    logic  sf_due = 1'b0;
    logic  held_v = 1'b0;
    data_t held_med;
    logic  held_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic data_t median_of(input data_t w [$]);
        data_t s [$];
        s = w;
        s.sort();
        return s[MID];
    endfunction

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int   nf;
        exp_t e;
        chk("short_frame", short_frame, sf_due);
        chk("fill_count", fill_count, fill_m);
        if (held_v) begin
            chk("hold_valid", strm.out_valid, 1'b1);
            chk("hold_median", strm.out_median, held_med);
            chk("hold_last", strm.out_last, held_last);
        end
        held_v    = strm.out_valid && !strm.out_ready && !rst;
        held_med  = strm.out_median;
        held_last = strm.out_last;
        if (strm.out_valid && strm.out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", strm.out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("out_median", strm.out_median, e.med);
                chk("out_last", strm.out_last, e.last);
            end
        end
        sf_due = 1'b0;
        if (rst) begin
            exp_q.delete();
            win_m.delete();
            fill_m = 0;
            held_v = 1'b0;
        end else if (strm.in_valid && strm.in_ready) begin
            win_m.push_front(strm.in_data);
            if (win_m.size() > WIN) void'(win_m.pop_back());
            nf = (fill_m == WIN) ? WIN : fill_m + 1;
            if (nf == WIN) exp_q.push_back('{med: median_of(win_m), last: strm.in_last});
            else if (strm.in_last) sf_due = 1'b1;
            fill_m = strm.in_last ? 0 : nf;
        end
    end

    task automatic send(input data_t d, input logic l);
        int n;
        n = 0;
        strm.in_valid = 1'b1;
        strm.in_data  = d;
        strm.in_last  = l;
        @(negedge clk);
        while (!strm.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!strm.in_ready) chk("send_timeout", strm.in_ready, 1'b1);
        @(posedge clk);
        #1;
        strm.in_valid = 1'b0;
        strm.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        strm.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called right after the emitting accept's edge.
    task automatic expect_out(input data_t m, input logic l);
        if (LAT == 2) begin
            chk("lat_early_valid", strm.out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("lat_valid", strm.out_valid, 1'b1);
        chk("lat_median", strm.out_median, m);
        chk("lat_last", strm.out_last, l);
    endtask

    initial begin
        rst            = 1'b1;
        strm.in_valid  = 1'b0;
        strm.in_data   = '0;
        strm.in_last   = 1'b0;
        strm.out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_in_ready", strm.in_ready, 1'b0);
        chk("rst_out_valid", strm.out_valid, 1'b0);
        chk("rst_out_median", strm.out_median, 32'd0);
        chk("rst_out_last", strm.out_last, 1'b0);
        chk("rst_fill", fill_count, 4'd0);
        rst = 1'b0;
        idle(1);

        // Warm-up and sliding
        for (int i = 1; i <= 10; i++) send(data_t'(i), 1'b0);
        chk("warm_no_out", strm.out_valid, 1'b0);
        send(32'd11, 1'b0);
        expect_out(32'd6, 1'b0);
        chk("warm_fill", fill_count, 4'd11);
        send(32'd100, 1'b0);
        expect_out(32'd7, 1'b0);
        send(32'd0, 1'b0);
        expect_out(32'd7, 1'b0);
        idle(3);

        // Backpressure
        strm.out_ready = 1'b0;
        send(32'd50, 1'b0);
        fork
            begin
                send(32'd60, 1'b0);
                send(32'd70, 1'b0);
            end
            begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", strm.in_ready, 1'b0);
                    @(posedge clk);
                    #1;
                end
                strm.out_ready = 1'b1;
            end
        join
        idle(4);

        // Close frame, then a short frame, then a full 0xFFFFFFFF window
        send(32'd9, 1'b1);
        idle(3);
        for (int i = 0; i < 3; i++) send(data_t'(200 + i), 1'b0);
        send(32'd203, 1'b1);
        chk("short_pulse", short_frame, 1'b1);
        chk("short_fill", fill_count, 4'd0);
        idle(1);
        chk("short_pulse_end", short_frame, 1'b0);
        chk("short_no_out", strm.out_valid, 1'b0);
        for (int i = 0; i < 10; i++) send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        expect_out(32'hFFFF_FFFF, 1'b0);
        idle(2);

        // Frame end carrying a median
        send(32'd5, 1'b1);
        idle(3);
        for (int i = 1; i <= 10; i++) send(data_t'(i), 1'b0);
        send(32'd11, 1'b1);
        expect_out(32'd6, 1'b1);
        chk("end_fill", fill_count, 4'd0);
        for (int i = 20; i < 30; i++) send(data_t'(i), 1'b0);
        idle(3);
        chk("after_end_no_out", strm.out_valid, 1'b0);
        chk("after_end_fill", fill_count, 4'd10);

        // Reset mid-stream
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", strm.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", strm.out_valid, 1'b0);
        chk("midrst_out_median", strm.out_median, 32'd0);
        chk("midrst_out_last", strm.out_last, 1'b0);
        chk("midrst_fill", fill_count, 4'd0);
        chk("midrst_short", short_frame, 1'b0);
        for (int i = 31; i <= 40; i++) send(data_t'(i), 1'b0);
        idle(2);
        chk("midrst_no_out", strm.out_valid, 1'b0);
        send(32'd41, 1'b0);
        expect_out(32'd36, 1'b0);
        idle(5);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
